layer_compositor: RTL and testbench

- Parametrised, pipelined successor to the fixed four-way OLED colour mux in the top level.
- Takes NUM_LAYERS colour layers plus a background colour and produces one registered pixel colour per clock.
- Supports per-layer enable, a transparent colour key, and frame-synchronised damage blinking per layer.
- Supports a frame-latched swap of the priority of layers 0 and 1, so the attacking sprite can be drawn on top.
- Sits between the sprite, status-bar and background generators and Oled_Display.

---
 rtl/layer_compositor.sv | 156 +++++++++++++++
 tb/tb_layer_compositor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: picks the highest-priority opaque layer over a background,
// with frame-latched swap of layers 0/1 and per-layer frame-synchronised damage blinking.
module layer_compositor #(
  parameter int               NUM_LAYERS   = 4,
  parameter int               COL_W        = 16,
  parameter int               IDX_W        = 13,
  parameter logic [COL_W-1:0] TRANSPARENT  = '0,
  parameter int               BLINK_HALF   = 3,
  parameter int               BLINK_PHASES = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        frame_begin,
  input  logic                        pixel_valid_in,
  input  logic [IDX_W-1:0]            pixel_index_in,
  input  logic [NUM_LAYERS*COL_W-1:0] layer_col,
  input  logic [COL_W-1:0]            bg_col,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS-1:0]       blink_req,
  input  logic                        swap_01,
  output logic                        pixel_valid_out,
  output logic [IDX_W-1:0]            pixel_index_out,
  output logic [COL_W-1:0]            pixel_out,
  output logic [3:0]                  hit_layer,
  output logic [NUM_LAYERS-1:0]       blinking
);

  localparam int PW = $clog2(BLINK_PHASES + 1);
  localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int LW = $clog2(NUM_LAYERS);
  localparam logic [FW-1:0] F_LAST   = FW'(BLINK_HALF - 1);
  localparam logic          HIDE_PAR = ((BLINK_PHASES % 2) == 1);

  logic                  swap_reg;
  logic [NUM_LAYERS-1:0] hidden;
  logic [NUM_LAYERS-1:0] blink_vec;
  logic [NUM_LAYERS-1:0] opaque_next;

  logic                  valid1_reg;
  logic [IDX_W-1:0]      index1_reg;
  logic [NUM_LAYERS-1:0] opaque1_reg;
  logic [COL_W-1:0]      cols1_reg [NUM_LAYERS];
  logic [COL_W-1:0]      bg1_reg;

  logic [COL_W-1:0]      col_next;
  logic [3:0]            hit_next;

  logic                  valid2_reg;
  logic [IDX_W-1:0]      index2_reg;
  logic [COL_W-1:0]      col2_reg;
  logic [3:0]            hit2_reg;

  // Swap only changes at a frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (!reset_n)
      swap_reg <= 1'b0;
    else if (frame_begin)
      swap_reg <= swap_01;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      logic [PW-1:0] phase_reg;
      logic [FW-1:0] frame_reg;
      logic          blink_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          phase_reg <= '0;
          frame_reg <= '0;
          blink_reg <= 1'b0;
        end else if (blink_req[gi]) begin
          phase_reg <= PW'(BLINK_PHASES);
          frame_reg <= '0;
          blink_reg <= 1'b1;
        end else if (frame_begin && (phase_reg != '0)) begin
          if (frame_reg == F_LAST) begin
            frame_reg <= '0;
            phase_reg <= phase_reg - 1'b1;
            if (phase_reg == PW'(1))
              blink_reg <= 1'b0;
          end else begin
            frame_reg <= frame_reg + 1'b1;
          end
        end
      end

      // Phase parity is chosen so the first phase after a request is the hidden one.
      assign hidden[gi]      = blink_reg & (phase_reg[0] == HIDE_PAR);
      assign blink_vec[gi]   = blink_reg;
      assign opaque_next[gi] = layer_en[gi]
                             & (layer_col[gi*COL_W +: COL_W] != TRANSPARENT)
                             & ~hidden[gi];

      always_ff @(posedge clk) begin
        if (!reset_n)
          cols1_reg[gi] <= '0;
        else
          cols1_reg[gi] <= layer_col[gi*COL_W +: COL_W];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid1_reg  <= 1'b0;
      index1_reg  <= '0;
      opaque1_reg <= '0;
      bg1_reg     <= '0;
    end else begin
      valid1_reg  <= pixel_valid_in;
      index1_reg  <= pixel_index_in;
      opaque1_reg <= opaque_next;
      bg1_reg     <= bg_col;
    end
  end

  // Walk from lowest to highest rank so the highest-ranked opaque layer is written last.
  always_comb begin
    logic [LW-1:0] phys;
    col_next = bg1_reg;
    hit_next = 4'hF;
    phys     = '0;
    for (int r = NUM_LAYERS - 1; r >= 0; r--) begin
      phys = LW'(r);
      if (swap_reg && (r < 2))
        phys = LW'(1 - r);
      if (opaque1_reg[phys]) begin
        col_next = cols1_reg[phys];
        hit_next = 4'(phys);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid2_reg <= 1'b0;
      index2_reg <= '0;
      col2_reg   <= '0;
      hit2_reg   <= 4'hF;
    end else begin
      valid2_reg <= valid1_reg;
      index2_reg <= index1_reg;
      col2_reg   <= col_next;
      hit2_reg   <= hit_next;
    end
  end

  assign pixel_valid_out = valid2_reg;
  assign pixel_index_out = index2_reg;
  assign pixel_out       = col2_reg;
  assign hit_layer       = hit2_reg;
  assign blinking        = blink_vec;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: vector table for priority/enable/key, plus
// sequences for swap latching, blink timing, blink restart and mid-blink reset.
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_begin;
  logic        pixel_valid_in;
  logic [12:0] pixel_index_in;
  logic [63:0] layer_col;
  logic [15:0] bg_col;
  logic [3:0]  layer_en;
  logic [3:0]  blink_req;
  logic        swap_01;
  logic        pixel_valid_out;
  logic [12:0] pixel_index_out;
  logic [15:0] pixel_out;
  logic [3:0]  hit_layer;
  logic [3:0]  blinking;

  int total = 0;
  int bad   = 0;

  layer_compositor dut (
    .clk(clk), .reset_n(reset_n), .frame_begin(frame_begin),
    .pixel_valid_in(pixel_valid_in), .pixel_index_in(pixel_index_in),
    .layer_col(layer_col), .bg_col(bg_col), .layer_en(layer_en),
    .blink_req(blink_req), .swap_01(swap_01),
    .pixel_valid_out(pixel_valid_out), .pixel_index_out(pixel_index_out),
    .pixel_out(pixel_out), .hit_layer(hit_layer), .blinking(blinking)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l0, l1, l2, l3, bg;
    logic [3:0]  en;
    logic [15:0] exp_col;
    logic [3:0]  exp_hit;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_layers(input logic [15:0] l0, l1, l2, l3, bg, input logic [3:0] en);
    layer_col = {l3, l2, l1, l0};
    bg_col    = bg;
    layer_en  = en;
  endtask

  // One pixel in, checked two cycles later; valid must last exactly one cycle.
  task automatic send_pix(input string name, input logic [12:0] idx,
                          input logic [15:0] exp_col, input logic [3:0] exp_hit);
    pixel_valid_in = 1'b1;
    pixel_index_in = idx;
    tick();
    pixel_valid_in = 1'b0;
    pixel_index_in = '0;
    tick();
    chk({name, ".col"},   32'(pixel_out),       32'(exp_col));
    chk({name, ".hit"},   32'(hit_layer),       32'(exp_hit));
    chk({name, ".idx"},   32'(pixel_index_out), 32'(idx));
    chk({name, ".valid"}, 32'(pixel_valid_out), 32'd1);
    tick();
    chk({name, ".vdrop"}, 32'(pixel_valid_out), 32'd0);
    $display("pix %s idx=%0d col=%h hit=%h", name, idx, exp_col, exp_hit);
  endtask

  task automatic pulse_frame(input logic swap);
    swap_01     = swap;
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
  endtask

  task automatic pulse_req(input logic [3:0] req);
    blink_req = req;
    tick();
    blink_req = '0;
  endtask

  // Full 18-frame blink: hidden while ((f-1)/3) is even, blinking drops on pulse 18.
  task automatic blink_run(input string name, input int layer, input logic [15:0] col);
    logic [3:0] mask;
    mask = 4'(1 << layer);
    for (int f = 1; f <= 18; f++) begin
      if ((((f - 1) / 3) % 2) == 0)
        send_pix($sformatf("%s.f%0d", name, f), 13'(f), 16'h0000, 4'hF);
      else
        send_pix($sformatf("%s.f%0d", name, f), 13'(f), col, 4'(layer));
      pulse_frame(1'b0);
      chk($sformatf("%s.blink%0d", name, f), 32'(blinking), (f < 18) ? 32'(mask) : 32'd0);
    end
    send_pix({name, ".after"}, 13'd999, col, 4'(layer));
  endtask

  initial begin
    reset_n = 1'b0; frame_begin = 1'b0; pixel_valid_in = 1'b0; pixel_index_in = '0;
    layer_col = '0; bg_col = '0; layer_en = '0; blink_req = '0; swap_01 = 1'b0;

    vecs[0] = '{16'h0000, 16'hF800, 16'h07E0, 16'h0000, 16'h001F, 4'hF, 16'hF800, 4'h1};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 4'hF, 16'h1234, 4'hF};
    vecs[2] = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h1234, 4'h0, 16'h1234, 4'hF};
    vecs[3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h0F0F, 4'hF, 16'hAAAA, 4'h0};
    vecs[4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h0F0F, 4'hE, 16'hBBBB, 4'h1};
    vecs[5] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h0F0F, 4'h8, 16'hDDDD, 4'h3};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h5555, 16'h0F0F, 4'hF, 16'h5555, 4'h3};
    vecs[7] = '{16'h0000, 16'h0000, 16'hCCCC, 16'h0000, 16'h0F0F, 4'hB, 16'h0F0F, 4'hF};

    tick();
    tick();
    chk("rst.valid", 32'(pixel_valid_out), 32'd0);
    chk("rst.idx",   32'(pixel_index_out), 32'd0);
    chk("rst.col",   32'(pixel_out),       32'd0);
    chk("rst.hit",   32'(hit_layer),       32'hF);
    chk("rst.blink", 32'(blinking),        32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      set_layers(vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3, vecs[i].bg, vecs[i].en);
      send_pix($sformatf("vec%0d", i), 13'(100 + i), vecs[i].exp_col, vecs[i].exp_hit);
    end

    // Swap requested mid-frame must wait for the next frame_begin.
    set_layers(16'hFFFF, 16'hF800, 16'h0000, 16'h0000, 16'h0000, 4'hF);
    swap_01 = 1'b1;
    tick();
    send_pix("swap.pre", 13'd10, 16'hFFFF, 4'h0);
    pulse_frame(1'b1);
    send_pix("swap.on", 13'd11, 16'hF800, 4'h1);
    swap_01 = 1'b0;
    tick();
    send_pix("swap.hold", 13'd12, 16'hF800, 4'h1);
    pulse_frame(1'b0);
    send_pix("swap.off", 13'd13, 16'hFFFF, 4'h0);

    // Blink on layer 0.
    set_layers(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'hF);
    pulse_req(4'b0001);
    chk("b0.start", 32'(blinking), 32'h1);
    blink_run("b0", 0, 16'hFFFF);

    // Blink on layer 2, restarted by a request coinciding with frame_begin.
    set_layers(16'h0000, 16'h0000, 16'h07E0, 16'h0000, 16'h0000, 4'hF);
    pulse_req(4'b0100);
    for (int f = 0; f < 5; f++) pulse_frame(1'b0);
    chk("b2.mid", 32'(blinking), 32'h4);
    blink_req   = 4'b0100;
    frame_begin = 1'b1;
    tick();
    blink_req   = '0;
    frame_begin = 1'b0;
    chk("b2.reload", 32'(blinking), 32'h4);
    blink_run("b2", 2, 16'h07E0);

    // Reset mid-blink with a pixel in flight.
    set_layers(16'h0000, 16'hF800, 16'h0000, 16'h0000, 16'h0000, 4'hF);
    pulse_req(4'b0010);
    pulse_frame(1'b0);
    pixel_valid_in = 1'b1;
    pixel_index_in = 13'd77;
    tick();
    pixel_valid_in = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mrst.valid", 32'(pixel_valid_out), 32'd0);
    chk("mrst.idx",   32'(pixel_index_out), 32'd0);
    chk("mrst.col",   32'(pixel_out),       32'd0);
    chk("mrst.hit",   32'(hit_layer),       32'hF);
    chk("mrst.blink", 32'(blinking),        32'd0);
    tick();
    chk("mrst.valid2", 32'(pixel_valid_out), 32'd0);
    send_pix("mrst.post", 13'd200, 16'hF800, 4'h1);
    chk("mrst.noblink", 32'(blinking), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
